dmem_master: RTL and testbench

- Processor-side initiator for the 32x16 data memory.
- Accepts load, store, block-copy and block-fill commands from the execute stage over a req/ready handshake.
- Sequences the memory's single `read` strobe so the combinational memory writes only at intended addresses.
- Returns load data and a one-cycle `done` pulse. Sits between the execute/writeback stages and the data memory.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_wr_seq.sv | 56 +++++
 rtl/dmem_master.sv | 189 ++++++++++++++++++
 tb/tb_dmem_master.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory master: command encodings, the master FSM states
// and the write-strobe sequencer phases.
package dmem_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 16;
    localparam int LW_DEF = 6;

    typedef enum logic [1:0] {
        OP_LD   = 2'b00,
        OP_ST   = 2'b01,
        OP_CPY  = 2'b10,
        OP_FILL = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD      = 3'd1,
        S_WSETUP  = 3'd2,
        S_WSTROBE = 3'd3,
        S_WHOLD   = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        WP_IDLE   = 2'd0,
        WP_SETUP  = 2'd1,
        WP_STROBE = 2'd2,
        WP_HOLD   = 2'd3
    } wr_phase_e;

endpackage

// File: rtl/dmem_wr_seq.sv
// Three-cycle write strobe sequencer (setup / strobe / hold). The memory writes
// whenever mem_read is low, so the strobe is held low for exactly one cycle.
module dmem_wr_seq
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic mem_read_o,
    output logic finish_o
);

    wr_phase_e phase_q, phase_d;
    logic      mem_read_q, mem_read_d;
    logic      finish_q, finish_d;

    // Phase sequencing; mem_read drops only on the SETUP->STROBE edge
    always_comb begin
        phase_d    = phase_q;
        mem_read_d = 1'b1;
        case (phase_q)
            WP_IDLE: begin
                if (start_i) begin
                    phase_d = WP_SETUP;
                end else begin
                    phase_d = WP_IDLE;
                end
            end
            WP_SETUP: begin
                phase_d    = WP_STROBE;
                mem_read_d = 1'b0;
            end
            WP_STROBE: phase_d = WP_HOLD;
            WP_HOLD:   phase_d = WP_IDLE;
            default:   phase_d = WP_IDLE;
        endcase
        finish_d = (phase_d == WP_HOLD);
    end

    // Sequencer registers; reset forces the strobe inactive immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= WP_IDLE;
            mem_read_q <= 1'b1;
            finish_q   <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            mem_read_q <= mem_read_d;
            finish_q   <= finish_d;
        end
    end

    assign mem_read_o = mem_read_q;
    assign finish_o   = finish_q;

endmodule

// File: rtl/dmem_master.sv
// Processor-side initiator for the data memory: load, store, ascending block copy and
// block fill, with all memory-facing signals registered.
module dmem_master
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF,
    parameter int LW = LW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [1:0]    op,
    input  logic [AW-1:0] addr,
    input  logic [AW-1:0] dst,
    input  logic [DW-1:0] wdata,
    input  logic [LW-1:0] len,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [LW-1:0] MAX_LEN = LW'(2**AW);

    function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] l);
        if (l > MAX_LEN) begin
            return MAX_LEN;
        end else begin
            return l;
        end
    endfunction

    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          wr_start_s;
    logic          wr_finish_s;

    dmem_wr_seq u_wr_seq (
        .clk        (clk),
        .rst        (rst),
        .start_i    (wr_start_s),
        .mem_read_o (mem_read),
        .finish_o   (wr_finish_s)
    );

    // Next-state logic; address/data only move in states where mem_read is high
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_d       = src_q;
        dst_d       = dst_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d  = op_e'(op);
                    src_d = addr;
                    dst_d = dst;
                    cnt_d = sat_len(len);
                    case (op_e'(op))
                        OP_LD: begin
                            mem_addr_d = addr;
                            state_d    = S_RD;
                        end
                        OP_ST: begin
                            mem_addr_d  = addr;
                            mem_wdata_d = wdata;
                            state_d     = S_WSETUP;
                        end
                        OP_CPY: begin
                            mem_addr_d = addr;
                            if (sat_len(len) == '0) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_RD;
                            end
                        end
                        OP_FILL: begin
                            mem_addr_d  = dst;
                            mem_wdata_d = wdata;
                            if (sat_len(len) == '0) begin
                                state_d = S_DONE;
                            end else begin
                                state_d = S_WSETUP;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                if (op_q == OP_LD) begin
                    rd_data_d = mem_rdata;
                    state_d   = S_DONE;
                end else begin
                    mem_wdata_d = mem_rdata;
                    mem_addr_d  = dst_q;
                    state_d     = S_WSETUP;
                end
            end
            S_WSETUP:  state_d = S_WSTROBE;
            S_WSTROBE: state_d = S_WHOLD;
            S_WHOLD: begin
                if (!wr_finish_s) begin
                    state_d = S_WHOLD;
                end else if (op_q == OP_ST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                cnt_d = cnt_q - LW'(1);
                src_d = src_q + AW'(1);
                dst_d = dst_q + AW'(1);
                if (cnt_q == LW'(1)) begin
                    state_d = S_DONE;
                end else if (op_q == OP_CPY) begin
                    mem_addr_d = src_q + AW'(1);
                    state_d    = S_RD;
                end else begin
                    mem_addr_d = dst_q + AW'(1);
                    state_d    = S_WSETUP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        wr_start_s = (state_d == S_WSETUP) && (state_q != S_WSETUP);
        done_d     = (state_d == S_DONE);
        ready_d    = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    // Master FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_LD;
            src_q       <= '0;
            dst_q       <= '0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_master.sv
// Scoreboard bench for dmem_master: a behavioural 32x16 memory that writes while
// mem_read is low, plus a queue of expected completions (cycle and load data).
module tb_dmem_master;

    logic        clk;
    logic        rst;
    logic        req;
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [4:0]  dst;
    logic [15:0] wdata;
    logic [5:0]  len;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] rd_data;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic [15:0] mem_rdata;

    logic [15:0] mem [32];

    typedef struct {
        int          exp_cyc;
        logic [15:0] exp_rd;
        bit          is_ld;
    } sb_t;

    sb_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int strobes  = 0;
    int viol     = 0;
    bit prev_low = 1'b0;
    logic [4:0]  prev_addr  = 5'd0;
    logic [15:0] prev_wdata = 16'd0;
    logic [4:0]  last_waddr = 5'd0;

    dmem_master dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .dst       (dst),
        .wdata     (wdata),
        .len       (len),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory model, strobe rules and completion scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        sb_t e;
        if (!mem_read) begin
            if (prev_low || mem_addr != prev_addr || mem_wdata != prev_wdata) viol++;
            mem[mem_addr] = mem_wdata;
            last_waddr    = mem_addr;
            strobes++;
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
        end
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("done_cycle", cyc, e.exp_cyc);
                if (e.is_ld) chk("rd_data", rd_data, e.exp_rd);
            end
        end
    end

    task automatic preset();
        for (int i = 0; i < 32; i++) mem[i] = 16'(i);
    endtask

    task automatic issue(input logic [1:0] o, input logic [4:0] a, input logic [4:0] d,
                         input logic [15:0] wd, input logic [5:0] l, input int lat,
                         input logic [15:0] erd);
        sb_t e;
        int  t;
        t = 0;
        @(negedge clk);
        while (!ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
        req   = 1'b1;
        op    = o;
        addr  = a;
        dst   = d;
        wdata = wd;
        len   = l;
        e.exp_cyc = cyc + lat;
        e.exp_rd  = erd;
        e.is_ld   = (o == 2'b00);
        sb_q.push_back(e);
        @(posedge clk);
        #1 req = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || !ready) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0 || !ready) chk("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int s0;
        rst = 1'b1; req = 1'b0; op = 2'b00; addr = 5'd0; dst = 5'd0;
        wdata = 16'd0; len = 6'd0;
        preset();
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_read", mem_read, 1);
        rst = 1'b0;

        // load 7
        s0 = strobes;
        issue(2'b00, 5'd7, 5'd0, 16'd0, 6'd0, 2, 16'h0007);
        wait_idle();
        chk("ld_strobes", strobes - s0, 0);

        // store 3, then load back
        s0 = strobes;
        issue(2'b01, 5'd3, 5'd0, 16'hBEEF, 6'd0, 4, 16'd0);
        wait_idle();
        chk("st_strobes", strobes - s0, 1);
        chk("st_addr", last_waddr, 3);
        issue(2'b00, 5'd3, 5'd0, 16'd0, 6'd0, 2, 16'hBEEF);
        wait_idle();
        chk("st_mem2", mem[2], 16'd2);
        chk("st_mem4", mem[4], 16'd4);

        // copy with wrap
        s0 = strobes;
        issue(2'b10, 5'd30, 5'd10, 16'd0, 6'd4, 21, 16'd0);
        wait_idle();
        chk("cpy_strobes", strobes - s0, 4);
        chk("cpy_mem10", mem[10], 16'd30);
        chk("cpy_mem11", mem[11], 16'd31);
        chk("cpy_mem12", mem[12], 16'd0);
        chk("cpy_mem13", mem[13], 16'd1);
        chk("cpy_mem14", mem[14], 16'd14);

        // fill
        s0 = strobes;
        issue(2'b11, 5'd0, 5'd5, 16'hAAAA, 6'd3, 13, 16'd0);
        wait_idle();
        chk("fill_strobes", strobes - s0, 3);
        chk("fill_mem5", mem[5], 16'hAAAA);
        chk("fill_mem6", mem[6], 16'hAAAA);
        chk("fill_mem7", mem[7], 16'hAAAA);
        chk("fill_mem8", mem[8], 16'd8);

        // zero-length copy
        s0 = strobes;
        issue(2'b10, 5'd2, 5'd20, 16'd0, 6'd0, 1, 16'd0);
        wait_idle();
        chk("len0_strobes", strobes - s0, 0);

        // overlapping copy replicates the source word
        preset();
        issue(2'b10, 5'd0, 5'd1, 16'd0, 6'd3, 16, 16'd0);
        wait_idle();
        chk("ovl_mem1", mem[1], 16'd0);
        chk("ovl_mem2", mem[2], 16'd0);
        chk("ovl_mem3", mem[3], 16'd0);
        chk("ovl_mem4", mem[4], 16'd4);

        // oversized length saturates to the full memory
        s0 = strobes;
        issue(2'b11, 5'd0, 5'd0, 16'h5A5A, 6'd63, 129, 16'd0);
        wait_idle();
        chk("sat_strobes", strobes - s0, 32);
        chk("sat_mem0", mem[0], 16'h5A5A);
        chk("sat_mem31", mem[31], 16'h5A5A);

        // request while busy is dropped
        preset();
        s0 = strobes;
        issue(2'b01, 5'd20, 5'd0, 16'h1234, 6'd0, 4, 16'd0);
        @(negedge clk);
        req = 1'b1; op = 2'b01; addr = 5'd21; wdata = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        req = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        chk("busy_strobes", strobes - s0, 1);
        chk("busy_mem20", mem[20], 16'h1234);
        chk("busy_mem21", mem[21], 16'd21);

        // async reset while the store strobe is low
        s0 = strobes;
        @(negedge clk);
        req = 1'b1; op = 2'b01; addr = 5'd9; wdata = 16'h9999;
        @(posedge clk);
        #1 req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("arst_mem_read", mem_read, 1);
        chk("arst_ready", ready, 1);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("arst_mem9", mem[9], 16'h9999);
        chk("arst_strobes", strobes - s0, 1);

        chk("sb_empty", sb_q.size(), 0);
        chk("strobe_rules", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
